// File: rtl/bsg_pipeline_share_rr_if.sv
// Handshake bundle between the requester ports and the shared pipeline.
// The slave modport is the sharing controller's view.
interface bsg_pipeline_share_rr_if #(
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned max_out_p      = 4,
  parameter int unsigned width_p        = 32,
  parameter int unsigned result_width_p = 16
);
  localparam int unsigned out_w_lp = $clog2(max_out_p + 1);

  logic [num_req_p-1:0]                 req_v_i;
  logic [num_req_p-1:0][2*width_p-1:0]  req_data_i;
  logic [num_req_p-1:0]                 req_ready_and_o;
  logic                                 pipe_v_o;
  logic [2*width_p-1:0]                 pipe_data_o;
  logic                                 pipe_ready_and_i;
  logic                                 pipe_v_i;
  logic [result_width_p-1:0]            pipe_data_i;
  logic                                 pipe_ready_and_o;
  logic [num_req_p-1:0]                 resp_v_o;
  logic [result_width_p-1:0]            resp_data_o;
  logic [num_req_p-1:0]                 resp_ready_and_i;
  logic [out_w_lp-1:0]                  outstanding_o;

  modport slave (
    input  req_v_i, req_data_i, pipe_ready_and_i, pipe_v_i, pipe_data_i, resp_ready_and_i,
    output req_ready_and_o, pipe_v_o, pipe_data_o, pipe_ready_and_o, resp_v_o, resp_data_o,
           outstanding_o
  );

  modport master (
    output req_v_i, req_data_i, pipe_ready_and_i, pipe_v_i, pipe_data_i, resp_ready_and_i,
    input  req_ready_and_o, pipe_v_o, pipe_data_o, pipe_ready_and_o, resp_v_o, resp_data_o,
           outstanding_o
  );
endinterface

// File: rtl/bsg_pipeline_share_rr.sv
// Round-robin sharing of one in-order pipeline among num_req_p requesters.
// A tag FIFO routes results back to their issuers; a credit count caps in-flight ops.
module bsg_pipeline_share_rr #(
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned max_out_p      = 4,
  parameter int unsigned width_p        = 32,
  parameter int unsigned result_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_pipeline_share_rr_if.slave  bus
);
  localparam int unsigned lg_req_lp = $clog2(num_req_p);
  localparam int unsigned out_w_lp  = $clog2(max_out_p + 1);
  localparam int unsigned ptr_w_lp  = (max_out_p > 1) ? $clog2(max_out_p) : 1;

  logic [lg_req_lp-1:0] last_q, last_d;
  logic [out_w_lp-1:0]  out_q, out_d;
  logic [ptr_w_lp-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [lg_req_lp-1:0] tag_q [max_out_p];
  logic [lg_req_lp-1:0] tag_d [max_out_p];

  logic                 have_grant;
  logic [lg_req_lp-1:0] grant_idx, cand, head;
  logic                 credit_ok, nonempty, issue, ret, pipe_rdy;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(max_out_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // First valid requester after last_q, wrapping
  always_comb begin
    have_grant = 1'b0;
    grant_idx  = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= num_req_p; k++) begin
      cand = lg_req_lp'((32'(last_q) + k) % num_req_p);
      if (!have_grant && bus.req_v_i[cand]) begin
        have_grant = 1'b1;
        grant_idx  = cand;
      end
    end
  end

  always_comb begin
    credit_ok = (out_q != out_w_lp'(max_out_p));
    nonempty  = (out_q != '0);
    head      = tag_q[rd_q];
    issue     = have_grant & credit_ok & bus.pipe_ready_and_i;
    pipe_rdy  = nonempty & bus.resp_ready_and_i[head];
    ret       = bus.pipe_v_i & pipe_rdy;

    last_d = last_q;
    out_d  = out_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    tag_d  = tag_q;
    if (issue) begin
      tag_d[wr_q] = grant_idx;
      wr_d        = ptr_inc(wr_q);
      last_d      = grant_idx;
    end
    if (ret) rd_d = ptr_inc(rd_q);
    if (issue && !ret)      out_d = out_q + out_w_lp'(1);
    else if (!issue && ret) out_d = out_q - out_w_lp'(1);
  end

  // Outputs are forced to idle while reset is asserted, independent of the clock
  always_comb begin
    bus.pipe_v_o         = reset_n_i & have_grant & credit_ok;
    bus.pipe_data_o      = (reset_n_i && have_grant) ? bus.req_data_i[grant_idx] : '0;
    bus.req_ready_and_o  = '0;
    if (reset_n_i && issue) bus.req_ready_and_o[grant_idx] = 1'b1;
    bus.resp_v_o         = '0;
    if (reset_n_i && bus.pipe_v_i && nonempty) bus.resp_v_o[head] = 1'b1;
    bus.resp_data_o      = reset_n_i ? bus.pipe_data_i : '0;
    bus.pipe_ready_and_o = reset_n_i & pipe_rdy;
    bus.outstanding_o    = reset_n_i ? out_q : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q <= lg_req_lp'(num_req_p - 1);
      out_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      for (int i = 0; i < int'(max_out_p); i++) tag_q[i] <= '0;
    end else begin
      last_q <= last_d;
      out_q  <= out_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      tag_q  <= tag_d;
    end
  end

  // A result with nothing outstanding means the pipeline and this block are out of sync
  a_no_orphan_result: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                       !(bus.pipe_v_i && (out_q == '0)))
    else $error("pipe_v_i asserted with no operation outstanding");

endmodule

// File: tb/tb_bsg_pipeline_share_rr.sv
// Bench for bsg_pipeline_share_rr: RR/credit model with result scoreboard, vector table,
// and directed credit-stall and async-reset sequences.
module tb_bsg_pipeline_share_rr;
  logic clk;
  logic rst_n;

  bsg_pipeline_share_rr_if                  ifa ();
  bsg_pipeline_share_rr_if #(.max_out_p(2)) ifb ();

  bsg_pipeline_share_rr dut_a (.clk_i(clk), .reset_n_i(rst_n), .bus(ifa.slave));
  bsg_pipeline_share_rr #(.max_out_p(2)) dut_b (.clk_i(clk), .reset_n_i(rst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] res;
  } sb_t;

  typedef struct {
    logic [3:0] req_v;
    logic       pipe_rdy;
    logic [3:0] resp_rdy;
    logic [3:0] exp_rdy;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int          m_last;
  int          m_out;
  sb_t         sb[$];
  logic [15:0] pq[$];
  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  vec_t        vt [20];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // One cycle on instance A: model the arbiter, compare, then advance model and pipeline
  task automatic step_a(input vec_t v, input int vi);
    logic [3:0]  e_rdy, e_resp;
    logic        e_pv, e_pra, cred, iss, ret;
    logic [63:0] pd;
    int          g, hd;
    string       t;
    ifa.req_v_i          = v.req_v;
    ifa.pipe_ready_and_i = v.pipe_rdy;
    ifa.resp_ready_and_i = v.resp_rdy;
    ifa.pipe_v_i         = (pq.size() > 0);
    ifa.pipe_data_i      = (pq.size() > 0) ? pq[0] : 16'h0;
    #1;
    g = -1;
    for (int k = 1; k <= 4; k++)
      if (g < 0 && v.req_v[(m_last + k) % 4]) g = (m_last + k) % 4;
    cred  = (m_out < 4);
    e_pv  = (g >= 0) && cred;
    e_rdy = 4'b0;
    if (e_pv && v.pipe_rdy) e_rdy[g] = 1'b1;
    e_resp = 4'b0;
    e_pra  = 1'b0;
    if (m_out > 0) begin
      hd    = sb[0].id;
      e_pra = v.resp_rdy[hd];
      if (ifa.pipe_v_i) e_resp[hd] = 1'b1;
    end
    t = $sformatf("v%0d", vi);
    chk({t, "_pipe_v"},     64'(ifa.pipe_v_o), 64'(e_pv));
    chk({t, "_req_rdy"},    64'(ifa.req_ready_and_o), 64'(e_rdy));
    chk({t, "_tbl_rdy"},    64'(ifa.req_ready_and_o), 64'(v.exp_rdy));
    if (g >= 0) chk({t, "_pipe_data"}, ifa.pipe_data_o, {op_b[g], op_a[g]});
    else        chk({t, "_pipe_data0"}, ifa.pipe_data_o, 64'h0);
    chk({t, "_resp_v"},     64'(ifa.resp_v_o), 64'(e_resp));
    chk({t, "_pipe_ready"}, 64'(ifa.pipe_ready_and_o), 64'(e_pra));
    chk({t, "_outstanding"}, 64'(ifa.outstanding_o), 64'(m_out));
    if (e_resp != 4'b0) chk({t, "_resp_data"}, 64'(ifa.resp_data_o), 64'(sb[0].res));
    iss = e_pv && v.pipe_rdy;
    ret = ifa.pipe_v_i && e_pra;
    pd  = ifa.pipe_data_o;
    @(posedge clk);
    if (ret) begin
      void'(sb.pop_front());
      void'(pq.pop_front());
    end
    if (iss) begin
      sb.push_back('{g, 16'(op_a[g] * op_b[g])});
      pq.push_back(16'(pd[31:0] * pd[63:32]));
      m_last = g;
    end
    m_out = m_out + int'(iss) - int'(ret);
    @(negedge clk);
  endtask

  initial begin
    int n;
    op_a = '{32'd3, 32'd7, 32'd11, 32'd13};
    op_b = '{32'd5, 32'd9, 32'd2, 32'd1000};
    vt = '{
      '{4'b1111, 1'b1, 4'hF, 4'b0001},  // reset priority 0,1,2,3,0
      '{4'b1111, 1'b1, 4'hF, 4'b0010},
      '{4'b1111, 1'b1, 4'hF, 4'b0100},
      '{4'b1111, 1'b1, 4'hF, 4'b1000},
      '{4'b1111, 1'b1, 4'hF, 4'b0001},
      '{4'b0000, 1'b1, 4'hF, 4'b0000},
      '{4'b1000, 1'b1, 4'hF, 4'b1000},  // skip idle: only 3 valid after last=0
      '{4'b1111, 1'b1, 4'hF, 4'b0001},
      '{4'b0000, 1'b1, 4'hF, 4'b0000},
      '{4'b0010, 1'b1, 4'b1101, 4'b0010},  // head-of-line: 1 then 3, 1 stalled
      '{4'b1000, 1'b1, 4'b1101, 4'b1000},
      '{4'b0000, 1'b1, 4'b1101, 4'b0000},
      '{4'b0000, 1'b1, 4'b1101, 4'b0000},
      '{4'b0000, 1'b1, 4'b1101, 4'b0000},
      '{4'b0000, 1'b1, 4'b1101, 4'b0000},
      '{4'b0000, 1'b1, 4'hF, 4'b0000},
      '{4'b0000, 1'b1, 4'hF, 4'b0000},
      '{4'b1111, 1'b0, 4'hF, 4'b0000},  // pipeline not ready
      '{4'b1111, 1'b1, 4'hF, 4'b0001},
      '{4'b0000, 1'b1, 4'hF, 4'b0000}
    };
    m_last = 3;
    m_out  = 0;

    rst_n = 1'b0;
    ifa.req_v_i = 4'b1111;  ifa.pipe_ready_and_i = 1'b1; ifa.resp_ready_and_i = 4'hF;
    ifa.pipe_v_i = 1'b0;    ifa.pipe_data_i = 16'h0;
    for (int i = 0; i < 4; i++) ifa.req_data_i[i] = {op_b[i], op_a[i]};
    ifb.req_v_i = 4'b0;     ifb.pipe_ready_and_i = 1'b1; ifb.resp_ready_and_i = 4'h0;
    ifb.pipe_v_i = 1'b0;    ifb.pipe_data_i = 16'h0;
    for (int i = 0; i < 4; i++) ifb.req_data_i[i] = 64'h0;
    ifb.req_data_i[2] = {32'd4, 32'd6};
    #12;
    chk("rst_pipe_v",  64'(ifa.pipe_v_o), 64'h0);
    chk("rst_req_rdy", 64'(ifa.req_ready_and_o), 64'h0);
    chk("rst_outst",   64'(ifa.outstanding_o), 64'h0);
    ifa.req_v_i = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Credit stall on the 2-credit instance: requester 2 valid, responses held off
    ifb.req_v_i = 4'b0100;
    #1;
    chk("b_pipe_data", ifb.pipe_data_o, {32'd4, 32'd6});
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (ifb.pipe_v_o && ifb.req_ready_and_o[2]) n++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    chk("b_issue_cnt", 64'(n), 64'd2);
    chk("b_outst_full", 64'(ifb.outstanding_o), 64'd2);
    chk("b_pipe_v_low", 64'(ifb.pipe_v_o), 64'h0);
    ifb.pipe_v_i = 1'b1; ifb.pipe_data_i = 16'h0018; ifb.resp_ready_and_i = 4'b0100;
    #1;
    chk("b_resp_v", 64'(ifb.resp_v_o), 64'b0100);
    chk("b_pipe_rdy", 64'(ifb.pipe_ready_and_o), 64'h1);
    chk("b_resp_data", 64'(ifb.resp_data_o), 64'h18);
    chk("b_no_same_cycle_issue", 64'(ifb.pipe_v_o), 64'h0);
    @(posedge clk);
    #1 ifb.pipe_v_i = 1'b0;
    @(negedge clk);
    chk("b_pipe_v_back", 64'(ifb.pipe_v_o), 64'h1);
    chk("b_outst_one", 64'(ifb.outstanding_o), 64'd1);
    ifb.req_v_i = 4'b0;
    ifb.pipe_v_i = 1'b1;
    @(posedge clk);
    #1 ifb.pipe_v_i = 1'b0;
    @(negedge clk);
    chk("b_outst_drained", 64'(ifb.outstanding_o), 64'd0);

    for (int i = 0; i < 20; i++) step_a(vt[i], i);

    // Build up three outstanding, then reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v = '{4'b1111, 1'b1, 4'h0, 4'(1 << (i + 1))};
      step_a(v, 100 + i);
    end
    chk("pre_rst_outst", 64'(ifa.outstanding_o), 64'd3);
    ifa.pipe_v_i = 1'b1; ifa.resp_ready_and_i = 4'hF; ifa.pipe_data_i = 16'hBEEF;
    rst_n = 1'b0;
    #1;
    chk("arst_pipe_v",    64'(ifa.pipe_v_o), 64'h0);
    chk("arst_req_rdy",   64'(ifa.req_ready_and_o), 64'h0);
    chk("arst_resp_v",    64'(ifa.resp_v_o), 64'h0);
    chk("arst_pipe_rdy",  64'(ifa.pipe_ready_and_o), 64'h0);
    chk("arst_outst",     64'(ifa.outstanding_o), 64'h0);
    chk("arst_pipe_data", ifa.pipe_data_o, 64'h0);
    chk("arst_resp_data", 64'(ifa.resp_data_o), 64'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_outst", 64'(ifa.outstanding_o), 64'h0);
    pq.delete();
    sb.delete();
    m_out  = 0;
    m_last = 3;
    ifa.pipe_v_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step_a('{4'b1111, 1'b1, 4'hF, 4'b0001}, 200);
    step_a('{4'b0000, 1'b1, 4'hF, 4'b0000}, 201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
